// File: rtl/demux32_1to4_buf_pkg.sv
// Shared constants and helpers for the buffered 1-to-4 word demultiplexer.
package demux32_1to4_buf_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int NUM_CH    = 4;
  localparam int SEL_W     = 2;
  localparam int COUNT_W   = 2;
  localparam int XFER_W    = 16;

  // Occupancy value of a full 2-entry channel FIFO.
  localparam logic [COUNT_W-1:0] FULL_COUNT  = 2'd2;
  localparam logic [COUNT_W-1:0] EMPTY_COUNT = 2'd0;

  // One-hot decode of a channel select.
  function automatic logic [NUM_CH-1:0] sel_decode(input logic [SEL_W-1:0] sel);
    logic [NUM_CH-1:0] onehot;
    case (sel)
      2'd0:    onehot = 4'b0001;
      2'd1:    onehot = 4'b0010;
      2'd2:    onehot = 4'b0100;
      2'd3:    onehot = 4'b1000;
      default: onehot = 4'b0000;
    endcase
    return onehot;
  endfunction

endpackage

// File: rtl/demux32_1to4_buf_fifo2_32bit.sv
// Two-entry FIFO used as one output channel of the demultiplexer.
// Push is ignored when full and pop is ignored when empty, so the caller may
// present raw requests. A push and pop in the same cycle keep the occupancy.
module fifo2_32bit
  import demux32_1to4_buf_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic [WIDTH-1:0]   din,
  output logic [WIDTH-1:0]   dout,
  output logic               valid,
  output logic [COUNT_W-1:0] count
);

  logic [WIDTH-1:0]   mem_r [0:1];
  logic               wr_ptr_r;
  logic               rd_ptr_r;
  logic [COUNT_W-1:0] count_r;
  logic               valid_r;
  logic               push_ok_s;
  logic               pop_ok_s;
  logic [COUNT_W-1:0] count_nxt_s;

  // Qualify requests against occupancy and compute the next occupancy.
  always_comb begin
    push_ok_s   = 1'b0;
    pop_ok_s    = 1'b0;
    count_nxt_s = count_r;
    if (push && (count_r != FULL_COUNT)) begin
      push_ok_s = 1'b1;
    end else begin
      push_ok_s = 1'b0;
    end
    if (pop && (count_r != EMPTY_COUNT)) begin
      pop_ok_s = 1'b1;
    end else begin
      pop_ok_s = 1'b0;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_nxt_s = count_r + 2'd1;
      2'b01:   count_nxt_s = count_r - 2'd1;
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage, pointers, occupancy and the registered non-empty flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_r[0] <= '0;
      mem_r[1] <= '0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= EMPTY_COUNT;
      valid_r  <= 1'b0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= din;
      end
      wr_ptr_r <= wr_ptr_r ^ push_ok_s;
      rd_ptr_r <= rd_ptr_r ^ pop_ok_s;
      count_r  <= count_nxt_s;
      valid_r  <= (count_nxt_s != EMPTY_COUNT);
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign valid = valid_r;
  assign count = count_r;

endmodule

// File: rtl/demux32_1to4_buf.sv
// Buffered 1-to-4 demultiplexer: one producer word is routed by in_sel into
// one of four 2-entry channel FIFOs, each drained by its own consumer.
// in_ready depends only on in_sel and registered occupancy, never on
// out_ready, so a full channel stays blocked even while it is being drained.
module demux32_1to4_buf
  import demux32_1to4_buf_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      in_ready,
  output logic [NUM_CH-1:0]         out_valid,
  output logic [NUM_CH*WIDTH-1:0]   out_data,
  input  logic [NUM_CH-1:0]         out_ready,
  output logic [NUM_CH*COUNT_W-1:0] ch_count,
  output logic [XFER_W-1:0]         xfer_count
);

  logic [COUNT_W-1:0] cnt_s [NUM_CH];
  logic [NUM_CH-1:0]  push_vec_s;
  logic [NUM_CH-1:0]  pop_vec_s;
  logic               in_ready_s;
  logic               push_any_s;
  logic [XFER_W-1:0]  xfer_count_r;

  // Ready select of the addressed channel and one-hot push gating.
  always_comb begin
    in_ready_s = 1'b0;
    push_any_s = 1'b0;
    push_vec_s = 4'b0000;
    if (cnt_s[in_sel] != FULL_COUNT) begin
      in_ready_s = 1'b1;
    end else begin
      in_ready_s = 1'b0;
    end
    push_any_s = in_valid && in_ready_s;
    if (push_any_s) begin
      push_vec_s = sel_decode(in_sel);
    end else begin
      push_vec_s = 4'b0000;
    end
  end

  assign pop_vec_s = out_valid & out_ready;

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_ch
      fifo2_32bit #(.WIDTH(WIDTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_vec_s[g]),
        .pop   (pop_vec_s[g]),
        .din   (in_data),
        .dout  (out_data[g*WIDTH +: WIDTH]),
        .valid (out_valid[g]),
        .count (cnt_s[g])
      );
      assign ch_count[g*COUNT_W +: COUNT_W] = cnt_s[g];
    end
  endgenerate

  // Accepted-word counter; wraps naturally at its width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_count_r <= 16'd0;
    end else if (push_any_s) begin
      xfer_count_r <= xfer_count_r + 16'd1;
    end
  end

  assign in_ready   = in_ready_s;
  assign xfer_count = xfer_count_r;

endmodule
